// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan controller and its detector.
package pattern_scan_pkg;

    localparam int unsigned PAT_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/pattern_det_moore.sv
// Moore serial detector for a PAT_W-bit pattern, oldest bit in pattern[PAT_W-1].
module pattern_det_moore
    import pattern_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap_en,
    output logic             det
);

    localparam int unsigned VCNT_W = $clog2(PAT_W + 1);
    localparam logic [VCNT_W-1:0] VcntFull = VCNT_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q;
    logic [VCNT_W-1:0] vcnt_q;

    // Decoded from state only, so det lags the completing bit by one edge.
    assign det = (vcnt_q == VcntFull) && (hist_q == pattern);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            vcnt_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            vcnt_q <= '0;
        end else if (shift_en) begin
            if (det && !overlap_en) begin
                // Non-overlapping: the next window starts with this bit.
                hist_q <= {{(PAT_W-1){1'b0}}, bit_in};
                vcnt_q <= VCNT_W'(1);
            end else begin
                hist_q <= {hist_q[PAT_W-2:0], bit_in};
                vcnt_q <= (vcnt_q == VcntFull) ? VcntFull : vcnt_q + VCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans a latched word MSB-first through a Moore pattern detector, counting matches
// and recording where the first one completed; reports with a one-cycle done pulse.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WORD_W-1:0]         word_in,
    input  logic [PAT_W-1:0]          pattern,
    input  logic                      overlap_en,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          match_count,
    output logic [$clog2(WORD_W)-1:0] first_pos
);

    localparam int unsigned POS_W = $clog2(WORD_W);
    // One extra bit so idx can reach WORD_W during DRAIN.
    localparam int unsigned IDX_W = $clog2(WORD_W + 1);

    scan_state_t       state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] word_q;
    logic [PAT_W-1:0]  pattern_q;
    logic              overlap_q;

    logic det;
    logic clear;
    logic shift_en;
    logic count_en;

    assign clear    = (state_q == StIdle) && start;
    assign shift_en = (state_q == StShift);
    assign count_en = ((state_q == StShift) || (state_q == StDrain)) && det;

    pattern_det_moore u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .shift_en  (shift_en),
        .bit_in    (word_q[WORD_W-1]),
        .pattern   (pattern_q),
        .overlap_en(overlap_q),
        .det       (det)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            word_q      <= '0;
            pattern_q   <= '0;
            overlap_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            first_pos   <= '0;
        end else begin
            done <= 1'b0;

            if (count_en) begin
                if (match_count != '1) begin
                    match_count <= match_count + CNT_W'(1);
                end
                if (match_count == '0) begin
                    first_pos <= POS_W'(idx_q - IDX_W'(1));
                end
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        word_q      <= word_in;
                        pattern_q   <= pattern;
                        overlap_q   <= overlap_en;
                        idx_q       <= '0;
                        match_count <= '0;
                        first_pos   <= '0;
                        busy        <= 1'b1;
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    // The word register shifts left so the current bit is always the MSB.
                    word_q <= {word_q[WORD_W-2:0], 1'b0};
                    idx_q  <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WORD_W - 1)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench: directed and random scans compared against a window-matching model.
module tb_pattern_scan_ctrl;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_in = '0;
    logic [3:0]  pattern = '0;
    logic        overlap_en = 1'b0;

    logic        busy5, done5, busy3, done3;
    logic [4:0]  cnt5;
    logic [2:0]  cnt3;
    logic [3:0]  fp5, fp3;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.WORD_W(16), .CNT_W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .word_in(word_in), .pattern(pattern),
        .overlap_en(overlap_en), .busy(busy5), .done(done5), .match_count(cnt5),
        .first_pos(fp5)
    );

    pattern_scan_ctrl #(.WORD_W(16), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .word_in(word_in), .pattern(pattern),
        .overlap_en(overlap_en), .busy(busy3), .done(done3), .match_count(cnt3),
        .first_pos(fp3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // Reference model: list of bit indices at which a match completes.
    bit m_active = 1'b0;
    int m_t = 0;
    int m_cnt = 0;
    int m_first = 0;
    bit m_done = 1'b0;
    int m_ends[$];

    function automatic void compute_ends(input logic [15:0] w, input logic [3:0] p,
                                         input bit ovl);
        int last;
        logic [3:0] win;
        last = -100;
        m_ends.delete();
        for (int k = 3; k < W; k++) begin
            win = {w[W-1-(k-3)], w[W-1-(k-2)], w[W-1-(k-1)], w[W-1-k]};
            if (win == p && (ovl || (k - last) >= 4)) begin
                m_ends.push_back(k);
                last = k;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int n;
        if (!rst_n) begin
            m_active = 1'b0;
            m_t = 0;
            m_cnt = 0;
            m_first = 0;
            m_done = 1'b0;
        end else begin
            if (!m_active) begin
                if (start) begin
                    compute_ends(word_in, pattern, overlap_en);
                    m_active = 1'b1;
                    m_t = 0;
                end
            end else begin
                m_t++;
                if (m_t == W + 2) m_active = 1'b0;
            end
            if (m_active) begin
                // A match ending at bit k is counted at edge k+2 after start.
                n = 0;
                foreach (m_ends[i]) if (m_ends[i] + 2 <= m_t) n++;
                m_cnt = n;
                m_first = (n > 0) ? m_ends[0] : 0;
            end
            m_done = m_active && (m_t == W + 1);
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("busy5", int'(busy5), int'(m_active));
            check("busy3", int'(busy3), int'(m_active));
            check("done5", int'(done5), int'(m_done));
            check("done3", int'(done3), int'(m_done));
            check("cnt5", int'(cnt5), sat(m_cnt, 31));
            check("cnt3", int'(cnt3), sat(m_cnt, 7));
            check("first5", int'(fp5), m_first);
            check("first3", int'(fp3), m_first);
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy5 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy5) check("idle_timeout", 0, 1);
    endtask

    // Pulses start for one cycle, measures start-to-done latency, checks literal results.
    task automatic run_scan(input logic [15:0] w, input logic [3:0] p, input bit ovl,
                            input int e5, input int ef, input int e3, input string tag);
        int n;
        bit got;
        @(posedge clk); #1;
        word_in = w; pattern = p; overlap_en = ovl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        word_in = 16'($urandom); pattern = 4'($urandom); overlap_en = 1'($urandom);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (done5) got = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
        else begin
            check({tag, "_latency"}, n, 17);
            if (e5 >= 0) begin
                check({tag, "_cnt5"}, int'(cnt5), e5);
                check({tag, "_first"}, int'(fp5), ef);
                check({tag, "_cnt3"}, int'(cnt3), e3);
            end
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [3:0]  p;
        #3;
        check("rst_busy", int'(busy5), 0);
        check("rst_done", int'(done5), 0);
        check("rst_cnt", int'(cnt5), 0);
        check("rst_first", int'(fp5), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        run_scan(16'hAA00, 4'b1010, 1'b1, 3, 3, 3, "aa00_ovl");
        run_scan(16'hAA00, 4'b1010, 1'b0, 2, 3, 2, "aa00_novl");
        run_scan(16'h0000, 4'b0000, 1'b1, 13, 3, 7, "zero_ovl");
        run_scan(16'h0000, 4'b0000, 1'b0, 4, 3, 4, "zero_novl");
        run_scan(16'h0009, 4'b1001, 1'b1, 1, 15, 1, "last_bit");
        run_scan(16'hFFFF, 4'b0000, 1'b1, 0, 0, 0, "no_match");

        // start pulsed mid-SHIFT with a different word must be ignored
        @(posedge clk); #1;
        word_in = 16'hAA00; pattern = 4'b1010; overlap_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        word_in = 16'h0000; pattern = 4'b0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        check("ignore_cnt", int'(cnt5), 3);
        check("ignore_first", int'(fp5), 3);
        run_scan(16'h0009, 4'b1001, 1'b0, 1, 15, 1, "after_ignore");

        // asynchronous reset in the middle of a scan
        @(posedge clk); #1;
        word_in = 16'h0000; pattern = 4'b0000; overlap_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy5), 0);
        check("arst_done", int'(done5), 0);
        check("arst_cnt", int'(cnt5), 0);
        check("arst_first", int'(fp5), 0);
        check("arst_cnt3", int'(cnt3), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_scan(16'hAA00, 4'b1010, 1'b0, 2, 3, 2, "after_reset");

        // start held high: back-to-back scans with changing inputs
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 62; i++) begin
            word_in = 16'($urandom); pattern = 4'($urandom); overlap_en = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 25; i++) begin
            p = 4'($urandom);
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w = {4{p}} ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) w = {4{p}};
            run_scan(w, p, 1'($urandom), -1, -1, -1, "rnd");
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller that scans a parallel data word for a programmable 4-bit serial pattern. On `start` it latches a word and a pattern, feeds the word MSB-first, one bit per clock, through a Moore-style pattern detector, counts the detections, records where the first one completed, and reports with a one-cycle `done` pulse. It is the control and scheduling wrapper for the serial Moore sequence-detector datapath, letting a parallel producer use that detector without bit-level handling.

## Interface
- `WORD_W`, 16: bits per scanned word; must be ≥ 4.
- `CNT_W`, 5: width of the match counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a scan; sampled only in IDLE.
- `word_in` input `WORD_W`: word to scan; latched on accepted `start`.
- `pattern` input 4: pattern, oldest bit in [3]; latched on accepted `start`.
- `overlap_en` input 1: 1 = overlapping matches count, 0 = detector restarts after each match; latched on accepted `start`.
- `busy` output 1: high from the accepted `start` edge until return to IDLE.
- `done` output 1: one-cycle pulse; results are valid.
- `match_count` output `CNT_W`: detections in the last scan, saturating.
- `first_pos` output `$clog2(WORD_W)`: index (0 = MSB) of the bit that completed the first match; 0 when `match_count` = 0.

## Operation
- FSM states: IDLE → SHIFT → DRAIN → DONE → IDLE.
- IDLE: `busy`=0. When `start`=1, latch `word_in`, `pattern` and `overlap_en`; clear the detector, the bit index, `match_count` and `first_pos`; go to SHIFT.
- SHIFT: each edge shifts bit `word[WORD_W-1-idx]` into the detector and increments `idx`. The edge that shifts the last bit moves the FSM to DRAIN.
- DRAIN: one cycle, so the Moore output for the final bit is counted. Then go to DONE.
- DONE: `done`=1 for this cycle only; go to IDLE.
- Detector (Moore):
  - State is `hist[3:0]` plus `vcnt` (0..4).
  - `det` = (`vcnt`==4 && `hist`==`pattern_q`), decoded from state only.
  - On shift with `det`=1 and `overlap_en_q`=0: `hist`←{3'b0,bit}, `vcnt`←1.
  - Otherwise: `hist`←{`hist[2:0]`,bit}, `vcnt`←min(`vcnt`+1,4).
  - `clear` sets `hist`=0, `vcnt`=0.
- Counting:
  - On every edge in SHIFT or DRAIN with `det`=1, `match_count` increments.
  - `match_count` saturates at 2^CNT_W−1.
  - On the first such event, `first_pos` ← `idx`−1, the index of the completing bit.
- `match_count` and `first_pos` hold their values after DONE until the next accepted `start`.
- `start` is ignored in SHIFT, DRAIN and DONE. No queuing.
- Reset values: state IDLE, `busy`=0, `done`=0, `match_count`=0, `first_pos`=0, detector cleared, latched word/pattern/`overlap_en` = 0.

## Timing
- Cycle numbering: accepted `start` at edge E0; `busy` is high from just after E0.
- Bits 0..WORD_W−1 are shifted at edges E1..E_WORD_W.
- The `det` result for bit k is visible after edge E(k+1) and counted at edge E(k+2).
- DRAIN is the cycle after E_WORD_W. `done` is high in the cycle after E_(WORD_W+1).
- `busy` falls after E_(WORD_W+2).
- Start-to-done latency is WORD_W+1 edges; back-to-back throughput is one scan per WORD_W+3 cycles.
- `start` held high continuously re-triggers on the first IDLE cycle after DONE.
- Reset asserted mid-scan: all outputs drop to reset values immediately, without waiting for a clock; no `done` is issued.
- The first `rst_n` rising edge is synchronised externally; the block needs no reset synchroniser.

## Structure
- Shared package `pattern_scan_pkg`:
  - FSM state enum `scan_state_t` (IDLE, SHIFT, DRAIN, DONE).
  - `PAT_W`=4 constant.
- Sub-module `pattern_det_moore`:
  - Ports: `clk`, `rst_n`, `clear`, `shift_en`, `bit_in`, `pattern[3:0]`, `overlap_en`, `det`.
  - Contains `hist`/`vcnt` and the Moore decode.
- The controller holds the FSM, the index counter, the word register and the result registers.

## Test plan
- Overlap on, WORD_W=16, `pattern`=4'b1010, `word_in`=16'hAA00 → `match_count`=3, `first_pos`=3, `done` exactly 17 edges after `start` edge.
- Same word, `overlap_en`=0 → `match_count`=2, `first_pos`=3.
- `pattern`=4'b0000, `word_in`=16'h0000 → overlap on: 13, `first_pos`=3; overlap off: 4. With CNT_W=3 and overlap on, `match_count` saturates at 7.
- `pattern`=4'b1001, `word_in`=16'h0009 → single match completing on the last bit: `match_count`=1, `first_pos`=15. This checks that DRAIN is counted.
- Scan 1 with `start` pulsed again mid-SHIFT, with a different `word_in` → ignored; results match the first word; a new `start` after `busy`=0 is accepted.
- `rst_n` asserted at cycle 8 of a scan → `busy`, `done`, `match_count`, `first_pos` go to 0 asynchronously. A subsequent scan gives correct results.
